// File: rtl/max7219_pkg.sv
// Shared constants, register image type and frame decode for the MAX7219 receiver.
package max7219_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // Power-up values of the mirrored register file
  localparam logic [7:0] DIGIT_RST     = 8'h00;
  localparam logic [7:0] DECODE_RST    = 8'h00;
  localparam logic [3:0] INTENSITY_RST = 4'h0;
  localparam logic [2:0] SCANLIM_RST   = 3'h0;
  localparam logic       SHUTDOWN_RST  = 1'b0;
  localparam logic       TEST_RST      = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0][7:0] digit;
    logic [7:0]      decode_mode;
    logic [3:0]      intensity;
    logic [2:0]      scan_limit;
    logic            shutdown_n;
    logic            test_mode;
  } regs_t;

  localparam regs_t REGS_RST = '{
    digit:       {8{DIGIT_RST}},
    decode_mode: DECODE_RST,
    intensity:   INTENSITY_RST,
    scan_limit:  SCANLIM_RST,
    shutdown_n:  SHUTDOWN_RST,
    test_mode:   TEST_RST
  };

  // Apply one latched frame to the register image; unknown addresses are no-ops
  function automatic regs_t apply_frame(input regs_t r, input logic [3:0] addr,
                                        input logic [7:0] data);
    regs_t n;
    n = r;
    case (addr)
      ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
      ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
        n.digit[3'(addr - 4'h1)] = data;
      ADDR_DECODE:    n.decode_mode = data;
      ADDR_INTENSITY: n.intensity   = data[3:0];
      ADDR_SCANLIM:   n.scan_limit  = data[2:0];
      ADDR_SHUTDOWN:  n.shutdown_n  = data[0];
      ADDR_TEST:      n.test_mode   = data[0];
      ADDR_NOOP:      n = r;
      default:        n = r;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/max7219_sync_edge.sv
// Multi-flop synchronizer with one extra flop for edge detection.
module max7219_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic _rst,
  input  logic d_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  // Next values: shift the raw input in, remember the previous synced level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect flops
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & edge_q;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 bus receiver: frames CS/CLK/Din into 16-bit words and mirrors the register file.
module max7219_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = max7219_pkg::FRAME_BITS
) (
  input  logic        sys_clk,
  input  logic        _rst,
  input  logic        CS,
  input  logic        CLK,
  input  logic        Din,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_err,
  output logic [63:0] digit_bus,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        test_mode
);

  import max7219_pkg::*;

  logic cs_lvl, cs_rise_c, cs_fall_c;
  logic clk_lvl, clk_rise_c, clk_fall_c;
  logic din_lvl, din_rise_c, din_fall_c;
  logic unused_sync;

  max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .sys_clk (sys_clk),
    ._rst    (_rst),
    .d_in    (CS),
    .level   (cs_lvl),
    .rise_c  (cs_rise_c),
    .fall_c  (cs_fall_c)
  );

  max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .sys_clk (sys_clk),
    ._rst    (_rst),
    .d_in    (CLK),
    .level   (clk_lvl),
    .rise_c  (clk_rise_c),
    .fall_c  (clk_fall_c)
  );

  // Din goes through the same depth so it lines up with its CLK edge
  max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .sys_clk (sys_clk),
    ._rst    (_rst),
    .d_in    (Din),
    .level   (din_lvl),
    .rise_c  (din_rise_c),
    .fall_c  (din_fall_c)
  );

  assign unused_sync = ^{cs_lvl, clk_lvl, clk_fall_c, din_rise_c, din_fall_c};

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  regs_t                 regs_q, regs_d;
  logic [3:0]            addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  // State register
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: CS low frames a transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall_c) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_rise_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: shift on CLK rise, latch or flag error on CS rise
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_c) begin
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_c) begin
          // A CLK edge coincident with CS rise is dropped
          if (cnt_q >= CNT_W'(FRAME_BITS)) begin
            addr_d  = shift_q[11:8];
            data_d  = shift_q[7:0];
            regs_d  = apply_frame(regs_q, shift_q[11:8], shift_q[7:0]);
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (clk_rise_c) begin
          shift_d = {shift_q[FRAME_BITS-2:0], din_lvl};
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      regs_q  <= REGS_RST;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign frame_addr  = addr_q;
  assign frame_data  = data_q;
  assign digit_bus   = regs_q.digit;
  assign decode_mode = regs_q.decode_mode;
  assign intensity   = regs_q.intensity;
  assign scan_limit  = regs_q.scan_limit;
  assign shutdown_n  = regs_q.shutdown_n;
  assign test_mode   = regs_q.test_mode;

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: directed frames, event-queue model checked every cycle.
module tb_max7219_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 3;

  logic        sys_clk = 1'b0;
  logic        _rst    = 1'b1;
  logic        CS      = 1'b1;
  logic        CLK     = 1'b0;
  logic        Din     = 1'b0;
  logic        frame_valid, frame_err, shutdown_n, test_mode;
  logic [3:0]  frame_addr, intensity;
  logic [7:0]  frame_data, decode_mode;
  logic [63:0] digit_bus;
  logic [2:0]  scan_limit;

  max7219_rx #(.SYNC_STAGES(SYNC)) dut (
    .sys_clk     (sys_clk),
    ._rst        (_rst),
    .CS          (CS),
    .CLK         (CLK),
    .Din         (Din),
    .frame_valid (frame_valid),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .digit_bus   (digit_bus),
    .decode_mode (decode_mode),
    .intensity   (intensity),
    .scan_limit  (scan_limit),
    .shutdown_n  (shutdown_n),
    .test_mode   (test_mode)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: what the register file must hold by the frame rules
  logic [7:0] m_dig [8];
  logic [7:0] m_decode;
  logic [3:0] m_int;
  logic [2:0] m_scan;
  logic       m_shut, m_test;
  logic [3:0] m_addr;
  logic [7:0] m_data;

  typedef struct {
    int unsigned cyc;
    bit          err;
    logic [15:0] word;
  } ev_t;
  ev_t evq[$];

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) m_dig[k] = 8'h00;
    m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0;
    m_shut = 1'b0; m_test = 1'b0; m_addr = 4'h0; m_data = 8'h00;
  endfunction

  function automatic void model_apply(input logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    m_addr = w[11:8];
    m_data = w[7:0];
    if (a >= 1 && a <= 8) m_dig[a-1] = w[7:0];
    else if (a == 9)  m_decode = w[7:0];
    else if (a == 10) m_int    = w[3:0];
    else if (a == 11) m_scan   = w[2:0];
    else if (a == 12) m_shut   = w[0];
    else if (a == 15) m_test   = w[0];
  endfunction

  function automatic logic [63:0] model_digits();
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = m_dig[k];
    return d;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge sys_clk) begin
    bit  exp_v, exp_e;
    ev_t ev;
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (!_rst) begin
      model_reset();
    end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
      ev = evq.pop_front();
      if (ev.err) exp_e = 1'b1;
      else begin
        exp_v = 1'b1;
        model_apply(ev.word);
      end
    end
    chk("frame_valid", 64'(frame_valid), 64'(exp_v));
    chk("frame_err",   64'(frame_err),   64'(exp_e));
    chk("frame_addr",  64'(frame_addr),  64'(m_addr));
    chk("frame_data",  64'(frame_data),  64'(m_data));
    chk("digit_bus",   digit_bus,        model_digits());
    chk("decode_mode", 64'(decode_mode), 64'(m_decode));
    chk("intensity",   64'(intensity),   64'(m_int));
    chk("scan_limit",  64'(scan_limit),  64'(m_scan));
    chk("shutdown_n",  64'(shutdown_n),  64'(m_shut));
    chk("test_mode",   64'(test_mode),   64'(m_test));
  end

  // Pulse counters used by the literal checks
  int n_valid = 0;
  int n_err   = 0;
  always @(negedge sys_clk) begin
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
  end

  bit in_frame = 1'b0;
  bit sent[$];

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cs_fall();
    step();
    CS = 1'b0;
    in_frame = 1'b1;
    sent.delete();
    idle(HALF);
  endtask

  task automatic send_bit(input bit b);
    step();
    Din = b;
    idle(HALF);
    step();
    CLK = 1'b1;
    if (in_frame) sent.push_back(b);
    idle(HALF);
    step();
    CLK = 1'b0;
  endtask

  // Raise CS and schedule the expected strobe from the bits sent so far
  task automatic cs_rise();
    ev_t         ev;
    logic [15:0] w;
    step();
    CS = 1'b1;
    if (in_frame) begin
      ev.cyc = cyc + SYNC + 1;
      ev.err = (sent.size() < 16);
      w = '0;
      if (!ev.err)
        for (int i = 0; i < 16; i++) w[15-i] = sent[sent.size()-16+i];
      ev.word = w;
      evq.push_back(ev);
    end
    in_frame = 1'b0;
    idle(HALF + 1);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    cs_fall();
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    cs_rise();
  endtask

  initial begin
    #1 _rst = 1'b0;
    // Reset held with the bus toggling
    for (int i = 0; i < 12; i++) begin
      step();
      CS  = 1'($urandom_range(0, 1));
      CLK = 1'($urandom_range(0, 1));
      Din = 1'($urandom_range(0, 1));
    end
    chk("rst_valid",  64'(frame_valid), 64'd0);
    chk("rst_err",    64'(frame_err),   64'd0);
    chk("rst_addr",   64'(frame_addr),  64'd0);
    chk("rst_data",   64'(frame_data),  64'd0);
    chk("rst_digits", digit_bus,        64'd0);
    chk("rst_shut",   64'(shutdown_n),  64'd0);
    chk("rst_test",   64'(test_mode),   64'd0);
    step();
    CS = 1'b1; CLK = 1'b0; Din = 1'b0;
    step();
    _rst = 1'b1;
    idle(6);

    send_bits(32'h0C01, 16);
    chk("wake_shut",  64'(shutdown_n), 64'd1);
    chk("wake_addr",  64'(frame_addr), 64'hC);
    chk("wake_data",  64'(frame_data), 64'h01);
    chk("wake_count", 64'(n_valid),    64'd1);

    send_bits(32'h01A5, 16);
    send_bits(32'h085A, 16);
    send_bits(32'h0A08, 16);
    send_bits(32'h0B07, 16);
    send_bits(32'h09FF, 16);
    chk("sweep_dig0",  64'(digit_bus[7:0]),   64'hA5);
    chk("sweep_dig7",  64'(digit_bus[63:56]), 64'h5A);
    chk("sweep_int",   64'(intensity),        64'h8);
    chk("sweep_scan",  64'(scan_limit),       64'h7);
    chk("sweep_dec",   64'(decode_mode),      64'hFF);
    chk("sweep_count", 64'(n_valid),          64'd6);

    send_bits(32'h03FF, 10);
    chk("short_err",   64'(n_err),          64'd1);
    chk("short_valid", 64'(n_valid),        64'd6);
    chk("short_dig0",  64'(digit_bus[7:0]), 64'hA5);
    chk("short_addr",  64'(frame_addr),     64'h9);

    send_bits(32'h0, 0);
    chk("empty_err", 64'(n_err), 64'd2);

    send_bits(32'hFF0312, 24);
    chk("over_dig2", 64'(digit_bus[23:16]), 64'h12);
    chk("over_addr", 64'(frame_addr),       64'h3);
    chk("over_data", 64'(frame_data),       64'h12);

    send_bits(32'h0055, 16);
    chk("noop0_addr", 64'(frame_addr), 64'h0);
    chk("noop0_data", 64'(frame_data), 64'h55);
    send_bits(32'h0D77, 16);
    chk("noopd_addr", 64'(frame_addr), 64'hD);
    chk("noopd_data", 64'(frame_data), 64'h77);
    chk("noop_dig2",  64'(digit_bus[23:16]), 64'h12);
    chk("noop_count", 64'(n_valid), 64'd9);

    // Reset in the middle of a frame, then finish the CS pulse
    cs_fall();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    step();
    _rst = 1'b0;
    in_frame = 1'b0;
    evq.delete();
    CLK = 1'b1;
    idle(2);
    CLK = 1'b0;
    idle(2);
    step();
    _rst = 1'b1;
    idle(4);
    cs_rise();
    idle(6);
    chk("midrst_valid", 64'(n_valid), 64'd9);
    chk("midrst_err",   64'(n_err),   64'd2);
    chk("midrst_dig",   digit_bus,    64'd0);

    send_bits(32'h0F01, 16);
    chk("test_mode", 64'(test_mode),  64'd1);
    chk("test_addr", 64'(frame_addr), 64'hF);
    chk("test_count", 64'(n_valid),   64'd10);

    idle(10);
    chk("queue_drained", 64'(evq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
